perf_event_counter: RTL and testbench
=====================================

# perf_event_counter

Synthesizable per-cycle event monitor for the pipelined CPU. It counts run cycles and NUM_EVT qualified event lines, such as stall and flush, and stops on its own after a programmable cycle limit. Counters are read back through a registered select/request port. It sits beside the CPU core on clk_i and takes the same start_i and rst_i, so counts line up with the core's own cycle numbering.

## Interface
- NUM_EVT, 2: number of event channels (1..15); channel 0 = stall and channel 1 = flush by convention
- CNT_W, 32: width of every counter (8..32)
- CYCLE_LIMIT, 30: run cycles before auto-stop; 0 = never stop
- SATURATE, 1: 1 = counters saturate at all-ones; 0 = counters wrap
- SEL_W, 4: read-select width; must satisfy 2^SEL_W > NUM_EVT
- clk_i  in  1  clock, rising-edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  run enable, level-sensitive
- clear_i  in  1  synchronous clear of all counters, flags and state
- evt_i  in  NUM_EVT  event strobes, sampled every rising edge
- rd_req_i  in  1  read request
- rd_sel_i  in  SEL_W  0 = cycle counter, k = event channel k-1
- rd_valid_o  out  1  one-cycle pulse, rd_data_o is valid
- rd_data_o  out  CNT_W  read data
- ovf_o  out  NUM_EVT+1  sticky overflow flags; bit 0 = cycle counter, bit k = channel k-1
- running_o  out  1  state == RUN
- done_o  out  1  state == DONE

## Operation
- FSM states:
  - IDLE: start_i=1 -> RUN.
  - RUN: start_i=0 -> IDLE. This is a pause; counters hold their values.
  - RUN: CYCLE_LIMIT≠0 and cyc == CYCLE_LIMIT-1 -> DONE.
  - DONE: holds until clear_i.
- clear_i wins over every other transition. The next state is IDLE and all counters and ovf bits are zeroed.
- Counting happens only on edges where the state is RUN:
  - cyc increments by 1 every edge.
  - event counter k increments when evt_i[k]=1.
  - Events on the edge that moves RUN -> DONE are counted.
- Events are ignored in IDLE and in DONE.
- Width rules:
  - Counters are CNT_W unsigned.
  - At all-ones with an increment pending: SATURATE=1 holds at all-ones; SATURATE=0 wraps to 0.
  - The matching ovf bit sets in both modes and stays set until clear_i or reset.
- Readout:
  - A rd_req_i edge registers the selected counter into rd_data_o and pulses rd_valid_o on the next cycle.
  - rd_sel_i > NUM_EVT returns 0 with rd_valid_o still pulsed.
  - rd_data_o holds its value between requests.
- Simultaneous read and count: the read returns the counter value before that edge's increment.
- Simultaneous read and clear_i: the read returns the pre-clear value, and the counters are zero on the following cycle.

## Timing
- Reset values, applied asynchronously while rst_i=0:
  - state = IDLE and all counters = 0.
  - rd_data_o = 0, rd_valid_o = 0, ovf_o = 0, running_o = 0, done_o = 0.
- Reset release: the first rising edge with rst_i=1 and start_i=1 enters RUN, and counting begins on the following edge.
- Reset in the middle of RUN or DONE zeroes everything immediately, without waiting for a clock edge.
- running_o and done_o are decoded from registered state, so they are glitch-free.
- done_o rises on the same edge on which cyc reaches CYCLE_LIMIT.
- Read latency is exactly 1 cycle. Back-to-back requests give back-to-back valid pulses with no bubble.
- ovf bits set on the same edge as the saturating or wrapping increment.

## Test plan
- Auto-stop and event counts (defaults): rst_i low for 1/4 cycle, then start_i=1 held; evt_i[0] high every 3rd RUN cycle, evt_i[1] high once.
  - Expected: done_o=1 after 30 counted edges, cyc=30, ch0=10, ch1=1, running_o=0.
  - Further events must leave all counts unchanged.
- Pause and resume: start_i dropped for 5 cycles after 10 RUN cycles, with evt_i[0]=1 held throughout.
  - Expected: cyc and ch0 freeze at 10 during the pause.
  - Expected after resume: done_o asserts with cyc=30 and ch0=30.
- Saturation versus wrap: CNT_W=8, CYCLE_LIMIT=0, evt_i[0] held high for 300 cycles.
  - SATURATE=1: ch0=255 and ovf_o[1]=1.
  - SATURATE=0: ch0=300 mod 256=44 and ovf_o[1]=1.
  - Both modes: cyc ovf_o[0]=1.
- Readout port: rd_req_i on 3 consecutive cycles with sel 0, 2 and 7 while in DONE.
  - Expected: three consecutive rd_valid_o pulses carrying 30, ch1, and 0 (sel 7 is out of range).
- Read and clear together: rd_req_i with sel=0 and clear_i=1 on the same edge in DONE.
  - Expected: rd_data_o=30, then all counters 0, done_o=0, state IDLE.
- Asynchronous reset mid-run: rst_i pulsed low between edges at cyc=12.
  - Expected: all outputs 0 immediately, without waiting for a clock edge.
  - Expected after release with start_i=1: counting restarts from 0.

Source files
------------

// File: rtl/perf_event_counter.sv
`timescale 1ns/1ps
// perf_event_counter
//
// Per-cycle event monitor placed beside the CPU core. While running it counts
// run cycles (counter 0) and NUM_EVT qualified event strobes (counters 1..NUM_EVT),
// and stops by itself after CYCLE_LIMIT counted cycles (0 = run forever).
// Counters either saturate at all-ones or wrap; either way a sticky overflow
// flag is raised for the affected counter.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       asynchronous, active-low reset
//   start_i     level-sensitive run enable; dropping it while running pauses
//   clear_i     synchronous clear of counters, overflow flags and state
//   evt_i       event strobes, one bit per channel
//   rd_req_i    read request, sampled each rising edge
//   rd_sel_i    0 = cycle counter, k = event channel k-1, > NUM_EVT reads 0
//   rd_valid_o  one-cycle pulse qualifying rd_data_o
//   rd_data_o   registered read data, held between requests
//   ovf_o       sticky overflow flags, bit 0 = cycle counter, bit k = channel k-1
//   running_o   state is RUN
//   done_o      state is DONE (cycle limit reached)
module perf_event_counter #(
    parameter int unsigned NUM_EVT     = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned CYCLE_LIMIT = 30,
    parameter int unsigned SATURATE    = 1,
    parameter int unsigned SEL_W       = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               rd_req_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic               rd_valid_o,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [NUM_EVT:0]   ovf_o,
    output logic               running_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);

    state_e             state_q;
    logic               running_q;
    logic               done_q;

    logic [CNT_W-1:0]   cnt_q [NUM_EVT+1];
    logic [CNT_W-1:0]   cnt_d [NUM_EVT+1];
    logic [NUM_EVT:0]   ovf_q;
    logic [NUM_EVT:0]   ovf_d;

    logic [CNT_W-1:0]   rd_data_q;
    logic [CNT_W-1:0]   rd_data_d;
    logic               rd_valid_q;
    logic [CNT_W-1:0]   rd_mux;

    logic               count_en;
    logic               limit_hit;
    logic [NUM_EVT:0]   inc;

    // A RUN edge with start_i low is the pause edge itself, so nothing is
    // counted on it; counters freeze at the value seen before start_i fell.
    assign count_en  = (state_q == ST_RUN) && start_i;
    assign limit_hit = count_en && (CYCLE_LIMIT != 0) && (cnt_q[0] == LIMIT_M1);
    assign inc       = {evt_i & {NUM_EVT{count_en}}, count_en};

    // ------------------------------------------------------------------
    // Control FSM with registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (clear_i) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // limit_hit already implies start_i, so it takes priority
                    // over the pause transition without ambiguity.
                    if (limit_hit) begin
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (!start_i) begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_DONE;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counter and overflow next-state
    // ------------------------------------------------------------------
    always_comb begin
        ovf_d = ovf_q;
        for (int unsigned i = 0; i <= NUM_EVT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc[i]) begin
                if (cnt_q[i] == '1) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = (SATURATE != 0) ? '1 : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        if (clear_i) begin
            ovf_d = '0;
            for (int unsigned i = 0; i <= NUM_EVT; i++) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '{default: '0};
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Readout: samples the pre-edge counter value, so a read coinciding
    // with an increment or a clear returns the old value.
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i <= NUM_EVT; i++) begin
            if (rd_sel_i == SEL_W'(i)) begin
                rd_mux = cnt_q[i];
            end
        end
    end

    assign rd_data_d = rd_req_i ? rd_mux : rd_data_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_req_i;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign ovf_o      = ovf_q;
    assign running_o  = running_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_perf_event_counter.sv
`timescale 1ns/1ps
module tb_perf_event_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst_n;
    logic        start;
    logic        clear;
    logic [1:0]  evt;
    logic        rd_req;
    logic [3:0]  rd_sel;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [2:0]  ovf;
    logic        running;
    logic        done;

    // 8-bit, no-limit instances (saturating and wrapping) sharing inputs
    logic        start8;
    logic [1:0]  evt8;
    logic        rd_req8;
    logic [3:0]  rd_sel8;
    logic        rdv_s, rdv_w;
    logic [7:0]  rdd_s, rdd_w;
    logic [2:0]  ovf_s, ovf_w;
    logic        run_s, run_w, done_s, done_w;

    perf_event_counter dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear),
        .evt_i(evt), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .ovf_o(ovf),
        .running_o(running), .done_o(done)
    );

    perf_event_counter #(.CNT_W(8), .CYCLE_LIMIT(0), .SATURATE(1)) dut_sat (
        .clk_i(clk), .rst_i(rst_n), .start_i(start8), .clear_i(1'b0),
        .evt_i(evt8), .rd_req_i(rd_req8), .rd_sel_i(rd_sel8),
        .rd_valid_o(rdv_s), .rd_data_o(rdd_s), .ovf_o(ovf_s),
        .running_o(run_s), .done_o(done_s)
    );

    perf_event_counter #(.CNT_W(8), .CYCLE_LIMIT(0), .SATURATE(0)) dut_wrap (
        .clk_i(clk), .rst_i(rst_n), .start_i(start8), .clear_i(1'b0),
        .evt_i(evt8), .rd_req_i(rd_req8), .rd_sel_i(rd_sel8),
        .rd_valid_o(rdv_w), .rd_data_o(rdd_w), .ovf_o(ovf_w),
        .running_o(run_w), .done_o(done_w)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_one(input logic [3:0] sel, input logic [31:0] exp, input string name);
        rd_req = 1'b1;
        rd_sel = sel;
        step();
        rd_req = 1'b0;
        check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check(name, rd_data, exp);
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    rd_vec_t tab [5];

    initial begin
        tab[0] = '{sel: 4'd0,  exp: 32'd30, name: "rd_cyc"};
        tab[1] = '{sel: 4'd2,  exp: 32'd1,  name: "rd_ch1"};
        tab[2] = '{sel: 4'd7,  exp: 32'd0,  name: "rd_sel7"};
        tab[3] = '{sel: 4'd15, exp: 32'd0,  name: "rd_sel15"};
        tab[4] = '{sel: 4'd1,  exp: 32'd10, name: "rd_ch0"};

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; evt = '0;
        rd_req = 1'b0; rd_sel = '0;
        start8 = 1'b0; evt8 = '0; rd_req8 = 1'b0; rd_sel8 = '0;

        // Reset state
        #1;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", {31'd0, rd_valid}, 0);
        check("rst_ovf", {29'd0, ovf}, 0);
        check("rst_running", {31'd0, running}, 0);
        check("rst_done", {31'd0, done}, 0);

        // Auto-stop with events
        start = 1'b1;
        #1.5 rst_n = 1'b1;
        step();
        check("run_entered", {31'd0, running}, 1);
        for (int n = 1; n <= 30; n++) begin
            evt[0] = (n % 3 == 0);
            evt[1] = (n == 5);
            step();
            if (n == 29) begin
                check("done_early", {31'd0, done}, 0);
                check("running_29", {31'd0, running}, 1);
            end
        end
        check("done_at_limit", {31'd0, done}, 1);
        check("running_after_done", {31'd0, running}, 0);
        evt = 2'b11;
        repeat (5) step();
        evt = '0;

        // Back-to-back reads from the table
        for (int i = 0; i < 5; i++) begin
            rd_req = 1'b1;
            rd_sel = tab[i].sel;
            step();
            check({tab[i].name, "_valid"}, {31'd0, rd_valid}, 1);
            check(tab[i].name, rd_data, tab[i].exp);
        end
        rd_req = 1'b0;
        step();
        check("valid_drop", {31'd0, rd_valid}, 0);
        check("rd_data_hold", rd_data, 10);
        check("ovf_none", {29'd0, ovf}, 0);

        // Read and clear on the same edge
        start = 1'b0;
        rd_req = 1'b1; rd_sel = 4'd0; clear = 1'b1;
        step();
        rd_req = 1'b0; clear = 1'b0;
        check("rdclr_data", rd_data, 30);
        check("rdclr_valid", {31'd0, rd_valid}, 1);
        check("rdclr_done", {31'd0, done}, 0);
        check("rdclr_running", {31'd0, running}, 0);
        rd_one(4'd0, 0, "clr_cyc");
        rd_one(4'd1, 0, "clr_ch0");
        rd_one(4'd2, 0, "clr_ch1");

        // Pause and resume
        evt = 2'b01;
        start = 1'b1;
        step();
        check("pr_running", {31'd0, running}, 1);
        repeat (10) step();
        start = 1'b0;
        step();
        check("pr_paused", {31'd0, running}, 0);
        rd_one(4'd0, 10, "pause_cyc");
        rd_one(4'd1, 10, "pause_ch0");
        step();
        step();
        start = 1'b1;
        step();
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 19) check("pr_done_early", {31'd0, done}, 0);
        end
        check("pr_done", {31'd0, done}, 1);
        rd_one(4'd0, 30, "pr_cyc");
        rd_one(4'd1, 30, "pr_ch0");
        evt = '0;
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Asynchronous reset mid-run
        evt = 2'b01;
        step();
        check("ar_running", {31'd0, running}, 1);
        repeat (12) step();
        #3 rst_n = 1'b0;
        #1;
        check("ar_rd_data", rd_data, 0);
        check("ar_rd_valid", {31'd0, rd_valid}, 0);
        check("ar_ovf", {29'd0, ovf}, 0);
        check("ar_running0", {31'd0, running}, 0);
        check("ar_done", {31'd0, done}, 0);
        #0.5 rst_n = 1'b1;
        step();
        check("ar_rerun", {31'd0, running}, 1);
        repeat (3) step();
        rd_one(4'd0, 3, "ar_cyc");
        rd_one(4'd1, 4, "ar_ch0");
        start = 1'b0;
        evt = '0;

        // Saturation versus wrap on 8-bit counters
        start8 = 1'b1;
        evt8 = 2'b01;
        step();
        for (int n = 1; n <= 300; n++) begin
            step();
            if (n == 255) begin
                check("sat_ovf_255", {29'd0, ovf_s}, 0);
                check("wrap_ovf_255", {29'd0, ovf_w}, 0);
            end
            if (n == 256) begin
                check("sat_ovf_256", {29'd0, ovf_s}, 3);
                check("wrap_ovf_256", {29'd0, ovf_w}, 3);
            end
        end
        start8 = 1'b0;
        step();
        rd_req8 = 1'b1; rd_sel8 = 4'd1;
        step();
        check("sat_ch0", {24'd0, rdd_s}, 255);
        check("wrap_ch0", {24'd0, rdd_w}, 44);
        rd_sel8 = 4'd0;
        step();
        check("sat_cyc", {24'd0, rdd_s}, 255);
        check("wrap_cyc", {24'd0, rdd_w}, 44);
        check("sat_valid", {31'd0, rdv_s}, 1);
        rd_req8 = 1'b0;
        check("sat_ovf_end", {29'd0, ovf_s}, 3);
        check("wrap_ovf_end", {29'd0, ovf_w}, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
